// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register responder.
package apb_reg_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DECODE   = 2'd1,
        S_EXT_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Classifies a latched APB byte address into internal register, external window or unmapped.
module apb_addr_decode
    import apb_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned EXT_SIZE   = 64,
    parameter int unsigned IDX_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  int_hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  ext_hit_o,
    output logic [ADDR_WIDTH-1:0] ext_off_o,
    output logic                  misaligned_o
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = log2(BYTES);
    localparam int unsigned INT_BYTES = REG_NUM * BYTES;
    localparam int unsigned AW1       = ADDR_WIDTH + 1;

    // One extra bit so an address below BASE_ADDR wraps high and falls out of every window.
    logic [AW1-1:0] off;

    assign off          = AW1'(addr_i) - AW1'(BASE_ADDR);
    assign misaligned_o = (off & AW1'(BYTES - 1)) != '0;
    assign int_hit_o    = off < AW1'(INT_BYTES);
    assign ext_hit_o    = (off >= AW1'(INT_BYTES)) && (off < AW1'(INT_BYTES + EXT_SIZE));
    assign idx_o        = IDX_W'(off >> OFF_W);
    assign ext_off_o    = ADDR_WIDTH'(off - AW1'(INT_BYTES));

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 responder producing register access strobes and forwarding an external window
// to a req/ack port guarded by a timeout.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned EXT_SIZE   = 64,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          pslverr,
    input  logic                          write_protect_en,
    output logic [REG_NUM-1:0]            sw_wr,
    output logic [REG_NUM-1:0]            sw_rd,
    output logic [DATA_WIDTH-1:0]         sw_wr_data,
    input  logic [REG_NUM*DATA_WIDTH-1:0] rd_data,
    output logic                          ext_req,
    output logic                          ext_wr,
    output logic [ADDR_WIDTH-1:0]         ext_addr,
    output logic [DATA_WIDTH-1:0]         ext_wr_data,
    input  logic                          ext_ack,
    input  logic [DATA_WIDTH-1:0]         ext_rd_data
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (REG_NUM > 1) ? log2(REG_NUM) : 1;
    localparam int unsigned CNT_W  = log2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;

    logic                    int_hit, ext_hit, misaligned;
    logic [IDX_W-1:0]        idx;
    logic [ADDR_WIDTH-1:0]   ext_off;
    logic [DATA_WIDTH-1:0]   rd_sel;
    logic                    dec_int, dec_ext, wr_fire;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_NUM    (REG_NUM),
        .BASE_ADDR  (BASE_ADDR),
        .EXT_SIZE   (EXT_SIZE),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i       (addr_q),
        .int_hit_o    (int_hit),
        .idx_o        (idx),
        .ext_hit_o    (ext_hit),
        .ext_off_o    (ext_off),
        .misaligned_o (misaligned)
    );

    always_comb begin
        rd_sel = '0;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (IDX_W'(r) == idx) rd_sel = rd_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign dec_int = (state_q == S_DECODE) && int_hit && !misaligned;
    assign dec_ext = (state_q == S_DECODE) && ext_hit && !misaligned;
    assign wr_fire = dec_int && write_q && !write_protect_en;

    assign sw_rd = (dec_int && !write_q) ? (REG_NUM'(1) << idx) : '0;
    assign sw_wr = wr_fire ? (REG_NUM'(1) << idx) : '0;

    // Unstrobed bytes keep the register's current contents.
    always_comb begin
        sw_wr_data = '0;
        if (wr_fire) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                sw_wr_data[b*8 +: 8] = strb_q[b] ? wdata_q[b*8 +: 8] : rd_sel[b*8 +: 8];
            end
        end
    end

    assign ext_req     = dec_ext || (state_q == S_EXT_WAIT);
    assign ext_wr      = ext_req && write_q;
    assign ext_addr    = ext_req ? ext_off : '0;
    assign ext_wr_data = ext_req ? wdata_q : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = RESP_OK;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_ext) begin
                    cnt_d   = '0;
                    state_d = S_EXT_WAIT;
                end else begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                    if (dec_int) begin
                        if (!write_q)              prdata_d  = rd_sel;
                        else if (write_protect_en) pslverr_d = RESP_ERR;
                    end else begin
                        pslverr_d = RESP_ERR;
                        prdata_d  = '0;
                    end
                end
            end
            S_EXT_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A late ack takes priority over a coincident timeout.
                if (ext_ack) begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                    if (!write_q) prdata_d = ext_rd_data;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = RESP_ERR;
                    prdata_d  = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Setup-phase capture; psel/penable are not looked at again until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (state_q == S_IDLE && psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: directed APB transfers, strobe/response monitor, ext responder.
module tb_apb_reg_slave;

    typedef struct {
        logic [7:0]  wr;
        logic [7:0]  rd;
        logic [31:0] data;
    } strobe_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic         clk;
    logic         rst_n;
    logic         psel, penable, pwrite;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic         write_protect_en;
    logic [7:0]   sw_wr, sw_rd;
    logic [31:0]  sw_wr_data;
    logic [255:0] rd_data;
    logic         ext_req, ext_wr;
    logic [15:0]  ext_addr;
    logic [31:0]  ext_wr_data;
    logic         ext_ack = 1'b0;
    logic [31:0]  ext_rd_data = 32'h0;

    logic [31:0]  reg_vals [8];
    strobe_t      strb_q [$];
    resp_t        resp_q [$];

    int           n_tests = 0;
    int           n_fail  = 0;

    int           ack_delay = -1;
    logic [31:0]  ack_data  = 32'h0;
    logic         exp_ext   = 1'b0;
    logic [15:0]  exp_ext_addr  = 16'h0;
    logic         exp_ext_wr    = 1'b0;
    logic [31:0]  exp_ext_wdata = 32'h0;
    int           ext_cnt = 0;
    int           ext_len = 0;

    apb_reg_slave #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .REG_NUM    (8),
        .BASE_ADDR  (0),
        .EXT_SIZE   (64),
        .TIMEOUT    (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .prdata           (prdata),
        .pready           (pready),
        .pslverr          (pslverr),
        .write_protect_en (write_protect_en),
        .sw_wr            (sw_wr),
        .sw_rd            (sw_rd),
        .sw_wr_data       (sw_wr_data),
        .rd_data          (rd_data),
        .ext_req          (ext_req),
        .ext_wr           (ext_wr),
        .ext_addr         (ext_addr),
        .ext_wr_data      (ext_wr_data),
        .ext_ack          (ext_ack),
        .ext_rd_data      (ext_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) rd_data[i*32 +: 32] = reg_vals[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_strb(input logic [7:0] wr, input logic [7:0] rd, input logic [31:0] data);
        strobe_t s;
        s.wr = wr; s.rd = rd; s.data = data;
        strb_q.push_back(s);
    endtask

    task automatic push_resp(input logic err, input logic [31:0] rdata);
        resp_t r;
        r.err = err; r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    // Monitor: pops expected strobes and responses whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sw_wr != 8'h0 || sw_rd != 8'h0) begin
                if (strb_q.size() == 0) begin
                    chk("strobe_unexpected", {sw_wr, sw_rd}, 16'h0);
                end else begin
                    strobe_t s;
                    s = strb_q.pop_front();
                    chk("sw_wr", 32'(sw_wr), 32'(s.wr));
                    chk("sw_rd", 32'(sw_rd), 32'(s.rd));
                    if (s.wr != 8'h0) chk("sw_wr_data", sw_wr_data, s.data);
                end
            end
            if (pready) begin
                if (resp_q.size() == 0) begin
                    chk("pready_unexpected", 32'(pready), 32'h0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("pslverr", 32'(pslverr), 32'(r.err));
                    chk("prdata", prdata, r.rdata);
                end
            end else begin
                chk("pslverr_idle", 32'(pslverr), 32'h0);
            end
        end
    end

    // External responder: checks the request on its first cycle and acks after ack_delay cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            ext_cnt = 0;
            ext_ack = 1'b0;
        end else if (ext_req) begin
            ext_cnt++;
            if (ext_cnt == 1) begin
                if (!exp_ext) begin
                    chk("ext_req_unexpected", 32'(ext_req), 32'h0);
                end else begin
                    chk("ext_addr", 32'(ext_addr), 32'(exp_ext_addr));
                    chk("ext_wr", 32'(ext_wr), 32'(exp_ext_wr));
                    if (exp_ext_wr) chk("ext_wr_data", ext_wr_data, exp_ext_wdata);
                end
            end
            ext_ack     = (ext_cnt == ack_delay);
            ext_rd_data = ext_ack ? ack_data : 32'hBAD0_0000;
        end else begin
            if (ext_cnt != 0) ext_len = ext_cnt;
            ext_cnt = 0;
            ext_ack = 1'b0;
        end
    end

    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int lat);
        int n;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        n = 1;
        while (!pready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pready) chk("pready_wait", 32'(pready), 32'h1);
        chk("latency", 32'(n), 32'(lat));
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic ext_setup(input logic [15:0] off, input logic wr, input logic [31:0] wd,
                             input int delay, input logic [31:0] ad);
        exp_ext = 1'b1; exp_ext_addr = off; exp_ext_wr = wr; exp_ext_wdata = wd;
        ack_delay = delay; ack_data = ad; ext_len = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'h0; pwdata = 32'h0; pstrb = 4'h0;
        write_protect_en = 1'b0;
        for (int i = 0; i < 8; i++) reg_vals[i] = 32'h0101_0101 * i;
        reg_vals[0] = 32'h0000_0011;
        reg_vals[2] = 32'hFFFF_0000;
        reg_vals[5] = 32'hDEAD_BEEF;

        @(negedge clk);
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_ext_req", 32'(ext_req), 32'h0);
        chk("rst_strobes", {sw_wr, sw_rd}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte-merged write to reg 2
        push_strb(8'h04, 8'h00, 32'hFFFF_1234);
        push_resp(1'b0, 32'h0);
        xfer(1'b1, 16'h0008, 32'hA5A5_1234, 4'b0011, 2);

        // Read reg 5
        push_strb(8'h00, 8'h20, 32'h0);
        push_resp(1'b0, 32'hDEAD_BEEF);
        xfer(1'b0, 16'h0014, 32'h0, 4'h0, 2);

        // Write-protected write: error, no strobe, prdata holds
        write_protect_en = 1'b1;
        push_resp(1'b1, 32'hDEAD_BEEF);
        xfer(1'b1, 16'h0000, 32'h1111_1111, 4'hF, 2);
        write_protect_en = 1'b0;

        // Misaligned read clears prdata
        push_resp(1'b1, 32'h0);
        xfer(1'b0, 16'h0002, 32'h0, 4'h0, 2);

        push_strb(8'h00, 8'h01, 32'h0);
        push_resp(1'b0, 32'h0000_0011);
        xfer(1'b0, 16'h0000, 32'h0, 4'h0, 2);

        // Unmapped read just past the external window
        push_resp(1'b1, 32'h0);
        xfer(1'b0, 16'h0060, 32'h0, 4'h0, 2);

        // Misaligned write
        push_resp(1'b1, 32'h0);
        xfer(1'b1, 16'h000A, 32'h2222_2222, 4'hF, 2);

        // External read, ack in T3
        ext_setup(16'h0004, 1'b0, 32'h0, 3, 32'h0000_00C3);
        push_resp(1'b0, 32'h0000_00C3);
        xfer(1'b0, 16'h0024, 32'h0, 4'h0, 4);
        #1 chk("ext_len_ack3", 32'(ext_len), 32'd3);

        // External write with no ack: timeout after 4 wait cycles
        ext_setup(16'h0010, 1'b1, 32'hCAFE_F00D, -1, 32'h0);
        push_resp(1'b1, 32'h0);
        xfer(1'b1, 16'h0030, 32'hCAFE_F00D, 4'hF, 6);
        #1 chk("ext_len_timeout", 32'(ext_len), 32'd5);

        // Ack coincident with timeout wins, last word of the window
        ext_setup(16'h003C, 1'b0, 32'h0, 5, 32'h1234_5678);
        push_resp(1'b0, 32'h1234_5678);
        xfer(1'b0, 16'h005C, 32'h0, 4'h0, 6);
        #1 chk("ext_len_race", 32'(ext_len), 32'd5);

        // External write, earliest ack; prdata holds
        ext_setup(16'h0000, 1'b1, 32'h5A5A_A5A5, 2, 32'h0);
        push_resp(1'b0, 32'h1234_5678);
        xfer(1'b1, 16'h0020, 32'h5A5A_A5A5, 4'hF, 3);
        #1 chk("ext_len_ack2", 32'(ext_len), 32'd2);

        // Reset while waiting on the external port
        ext_setup(16'h0000, 1'b0, 32'h0, -1, 32'h0);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0020;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("ext_req_before_rst", 32'(ext_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ext_req_async", 32'(ext_req), 32'h0);
        chk("rst_pready_async", 32'(pready), 32'h0);
        chk("rst_prdata_async", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ext = 1'b0;
        ack_delay = -1;

        // Normal transfers after reset, back to back
        push_strb(8'h00, 8'h20, 32'h0);
        push_resp(1'b0, 32'hDEAD_BEEF);
        xfer(1'b0, 16'h0014, 32'h0, 4'h0, 2);

        push_strb(8'h80, 8'h00, 32'h0BAD_CAFE);
        push_resp(1'b0, 32'hDEAD_BEEF);
        xfer(1'b1, 16'h001C, 32'h0BAD_CAFE, 4'hF, 2);

        repeat (3) @(negedge clk);
        chk("strobe_queue_empty", 32'(strb_q.size()), 32'h0);
        chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
